// File: rtl/bram_noc_ep.sv
// NoC endpoint owning one BRAM port: runs read/write bursts in order and returns
// read data or a write ack through a 2-entry response buffer.
module bram_noc_ep #(
   parameter int DATASIZE  = 32,
   parameter int ADDRWIDTH = 10,
   parameter int LENWIDTH  = 8,
   parameter int NODEWIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_wr,
   input  logic [NODEWIDTH-1:0] req_src,
   input  logic [ADDRWIDTH-1:0] req_addr,
   input  logic [LENWIDTH-1:0]  req_len,
   input  logic [DATASIZE-1:0]  req_data,
   output logic                 bram_we,
   output logic [ADDRWIDTH-1:0] bram_addr,
   output logic [DATASIZE-1:0]  bram_di,
   input  logic [DATASIZE-1:0]  bram_do,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [NODEWIDTH-1:0] rsp_dst,
   output logic [DATASIZE-1:0]  rsp_data,
   output logic                 rsp_ack,
   output logic                 rsp_last
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   typedef struct packed {
      logic [DATASIZE-1:0] data;
      logic                ack;
      logic                last;
   } entry_t;

   state_t               state_q, state_d;
   logic [ADDRWIDTH-1:0] addr_q, addr_d;
   logic [LENWIDTH-1:0]  cnt_q, cnt_d;
   logic [NODEWIDTH-1:0] src_q, src_d;
   logic                 inflight_q, inflight_d;
   logic                 inlast_q, inlast_d;

   entry_t               rbuf [2];
   logic                 wptr_q, rptr_q;
   logic [1:0]           occ_q;

   logic                 push, pop, can_issue, ready_int, we_int;
   entry_t               push_entry, head;

   assign pop = rsp_valid & rsp_ready;
   // A word in flight already owns a buffer slot, so count it before issuing another.
   assign can_issue = ({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});

   // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      src_d      = src_q;
      inflight_d = 1'b0;
      inlast_d   = inlast_q;
      ready_int  = 1'b0;
      we_int     = 1'b0;
      push       = 1'b0;
      push_entry = '0;

      if (inflight_q) begin
         push            = 1'b1;
         push_entry.data = bram_do;
         push_entry.last = inlast_q;
      end

      case (state_q)
         IDLE: begin
            ready_int = (occ_q == 2'd0) && !inflight_q;
            if (req_valid && ready_int) begin
               addr_d  = req_addr;
               cnt_d   = req_len;
               src_d   = req_src;
               state_d = req_wr ? WRITE : READ;
            end
         end
         WRITE: begin
            ready_int = 1'b1;
            if (req_valid) begin
               we_int = 1'b1;
               addr_d = addr_q + ADDRWIDTH'(1);
               cnt_d  = cnt_q - LENWIDTH'(1);
               if (cnt_q == '0) begin
                  push            = 1'b1;
                  push_entry.ack  = 1'b1;
                  push_entry.last = 1'b1;
                  state_d         = DRAIN;
               end
            end
         end
         READ: begin
            if (can_issue) begin
               inflight_d = 1'b1;
               inlast_d   = (cnt_q == '0);
               addr_d     = addr_q + ADDRWIDTH'(1);
               cnt_d      = cnt_q - LENWIDTH'(1);
               if (cnt_q == '0) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (occ_q == 2'd0 && !inflight_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         src_q      <= '0;
         inflight_q <= 1'b0;
         inlast_q   <= 1'b0;
         wptr_q     <= 1'b0;
         rptr_q     <= 1'b0;
         occ_q      <= 2'd0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         src_q      <= src_d;
         inflight_q <= inflight_d;
         inlast_q   <= inlast_d;
         if (push) wptr_q <= ~wptr_q;
         if (pop)  rptr_q <= ~rptr_q;
         occ_q <= occ_q + 2'(push) - 2'(pop);
      end
   end

   // NOTE: buffer storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      if (push) rbuf[wptr_q] <= push_entry;
   end

   assign req_ready = rst_n & ready_int;
   assign bram_we   = rst_n & we_int;
   assign bram_addr = rst_n ? addr_q : '0;
   assign bram_di   = req_data;
   assign rsp_valid = rst_n & (occ_q != 2'd0);
   assign head      = rsp_valid ? rbuf[rptr_q] : '0;
   assign rsp_data  = head.data;
   assign rsp_ack   = head.ack;
   assign rsp_last  = head.last;
   assign rsp_dst   = rsp_valid ? src_q : '0;

endmodule

// File: tb/tb_bram_noc_ep.sv
// Directed bench for bram_noc_ep with a behavioural read-first BRAM behind the port.
module tb_bram_noc_ep;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_wr;
   logic [3:0]  req_src;
   logic [9:0]  req_addr;
   logic [7:0]  req_len;
   logic [31:0] req_data;
   logic        bram_we;
   logic [9:0]  bram_addr;
   logic [31:0] bram_di, bram_do;
   logic        rsp_valid, rsp_ready;
   logic [3:0]  rsp_dst;
   logic [31:0] rsp_data;
   logic        rsp_ack, rsp_last;

   logic [31:0] mem [1024];
   int          errors = 0;
   int          checks = 0;

   bram_noc_ep dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_src(req_src), .req_addr(req_addr), .req_len(req_len), .req_data(req_data),
      .bram_we(bram_we), .bram_addr(bram_addr), .bram_di(bram_di), .bram_do(bram_do),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dst(rsp_dst),
      .rsp_data(rsp_data), .rsp_ack(rsp_ack), .rsp_last(rsp_last)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bram_we) mem[bram_addr] <= bram_di;
      bram_do <= mem[bram_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Presents a header, waits (bounded) for acceptance, leaves the bench in cycle T+1.
   task automatic send_header(input logic wr, input logic [3:0] src,
                              input logic [9:0] a, input logic [7:0] len);
      req_valid = 1'b1;
      req_wr    = wr;
      req_src   = src;
      req_addr  = a;
      req_len   = len;
      #1;
      for (int n = 0; n < 30 && !req_ready; n++) begin
         tick;
         #1;
      end
      check("hdr_ready", req_ready, 1);
      tick;
      req_valid = 1'b0;
   endtask

   task automatic write_beats(input logic [3:0] src, input logic [9:0] a, input int n,
                              input logic [31:0] d0, input logic [31:0] step);
      for (int k = 0; k < n; k++) begin
         logic [9:0] ea;
         ea        = a + 10'(k);
         req_valid = 1'b1;
         req_data  = d0 + step * 32'(k);
         #1;
         check("wr_we", bram_we, 1);
         check("wr_addr", bram_addr, 32'(ea));
         check("wr_di", bram_di, d0 + step * 32'(k));
         tick;
      end
      req_valid = 1'b0;
      #1;
      check("ack_valid", rsp_valid, 1);
      check("ack_flag", rsp_ack, 1);
      check("ack_last", rsp_last, 1);
      check("ack_data", rsp_data, 0);
      check("ack_dst", rsp_dst, 32'(src));
      tick;
   endtask

   task automatic read_burst(input logic [3:0] src, input logic [9:0] a, input int n,
                             input logic [31:0] d0, input logic [31:0] step);
      send_header(1'b0, src, a, 8'(n - 1));
      #1;
      check("rd_issue_addr", bram_addr, 32'(a));
      check("rd_t1_empty", rsp_valid, 0);
      tick;
      #1;
      check("rd_t2_empty", rsp_valid, 0);
      tick;
      for (int k = 0; k < n; k++) begin
         #1;
         check("rd_valid", rsp_valid, 1);
         check("rd_data", rsp_data, d0 + step * 32'(k));
         check("rd_last", rsp_last, (k == n - 1) ? 1 : 0);
         check("rd_ack", rsp_ack, 0);
         check("rd_dst", rsp_dst, 32'(src));
         tick;
      end
      #1;
      check("rd_done_empty", rsp_valid, 0);
   endtask

   initial begin
      logic [15:0] pat;
      logic [9:0]  prev;
      int          issues, pops, beats, maxo;

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_src   = '0;
      req_addr  = '0;
      req_len   = '0;
      req_data  = '0;
      rsp_ready = 1'b1;
      tick;
      tick;
      check("rst_req_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_bram_we", bram_we, 0);
      check("rst_bram_addr", bram_addr, 0);
      check("rst_rsp_dst", rsp_dst, 0);
      rst_n = 1'b1;
      #1;
      check("idle_ready", req_ready, 1);

      // Write A0..A3 to 0x010..0x013, then read them back.
      send_header(1'b1, 4'd3, 10'h010, 8'd3);
      write_beats(4'd3, 10'h010, 4, 32'h0000_00A0, 32'd1);
      check("mem_010", mem[16], 32'h0000_00A0);
      check("mem_013", mem[19], 32'h0000_00A3);
      read_burst(4'd5, 10'h010, 4, 32'h0000_00A0, 32'd1);

      // Fill 0x100..0x107, then read them under a fixed back-pressure pattern.
      send_header(1'b1, 4'd2, 10'h100, 8'd7);
      write_beats(4'd2, 10'h100, 8, 32'hC000_0100, 32'd1);
      send_header(1'b0, 4'd6, 10'h100, 8'd7);
      pat    = 16'b0110_1101_0011_1000;
      prev   = 10'h100;
      issues = 0;
      pops   = 0;
      beats  = 0;
      maxo   = 0;
      for (int c = 0; c < 200 && beats < 8; c++) begin
         rsp_ready = pat[c % 16];
         #1;
         if (bram_addr != prev) issues++;
         prev = bram_addr;
         if (issues - pops > maxo) maxo = issues - pops;
         if (rsp_valid && rsp_ready) begin
            check("bp_data", rsp_data, 32'hC000_0100 + 32'(beats));
            check("bp_last", rsp_last, (beats == 7) ? 1 : 0);
            beats++;
            pops++;
         end
         tick;
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_beats", 32'(beats), 8);
      check("bp_issues", 32'(issues), 8);
      check("bp_max_outstanding", 32'(maxo), 2);
      check("bp_no_extra", rsp_valid, 0);

      // Address wrap at the top of the BRAM.
      send_header(1'b1, 4'd1, 10'h3FF, 8'd1);
      write_beats(4'd1, 10'h3FF, 2, 32'h1111_1111, 32'h1111_1111);
      check("mem_3ff", mem[1023], 32'h1111_1111);
      check("mem_000", mem[0], 32'h2222_2222);
      read_burst(4'd1, 10'h3FF, 2, 32'h1111_1111, 32'h1111_1111);

      // Write with gaps between data beats.
      send_header(1'b1, 4'd7, 10'h020, 8'd1);
      req_valid = 1'b1;
      req_data  = 32'hDEAD_0000;
      #1;
      check("gap_we0", bram_we, 1);
      check("gap_addr0", bram_addr, 32'h020);
      tick;
      req_valid = 1'b0;
      req_data  = 32'hBAD0_BAD0;
      #1;
      check("gap_we_idle", bram_we, 0);
      check("gap_no_ack", rsp_valid, 0);
      tick;
      #1;
      check("gap_we_idle2", bram_we, 0);
      tick;
      write_beats(4'd7, 10'h021, 1, 32'hDEAD_0001, 32'd0);
      check("mem_020", mem[32], 32'hDEAD_0000);
      check("mem_021", mem[33], 32'hDEAD_0001);

      // Reset in the middle of a 6-word read after 2 beats have returned.
      send_header(1'b0, 4'd9, 10'h100, 8'd5);
      tick;
      tick;
      #1;
      check("mid_beat0", rsp_data, 32'hC000_0100);
      tick;
      #1;
      check("mid_beat1", rsp_data, 32'hC000_0101);
      tick;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", rsp_valid, 0);
      check("mid_rst_ready", req_ready, 0);
      tick;
      #1;
      check("post_rst_valid", rsp_valid, 0);
      check("post_rst_ready", req_ready, 0);
      check("post_rst_we", bram_we, 0);
      check("post_rst_data", rsp_data, 0);
      rst_n     = 1'b1;
      req_valid = 1'b1;
      req_wr    = 1'b0;
      #1;
      check("rel_ready", req_ready, 1);
      read_burst(4'd4, 10'h010, 1, 32'h0000_00A0, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
